opb_register_bank_simulink2ppc: RTL and testbench
=================================================

// Module: opb_register_bank_simulink2ppc
// PURPOSE
//  Multi-channel successor to the single simulink2ppc software register: C_NUM_CH user words, C_DATA_W bits each,
//  readable by the PPC over OPB. Adds per-channel valid qualification, a live/snapshot mode with atomic
//  capture of all channels, and a snapshot counter. User logic runs on OPB_Clk (single clock, no CDC).
// PARAMETERS
//  C_BASEADDR    32'h01002100  OPB base address (word aligned)
//  C_HIGHADDR    32'h010021FF  OPB high address; must satisfy HIGH-BASE+1 >= 16+4*C_NUM_CH (elaboration error otherwise)
//  C_OPB_AWIDTH  32            OPB address width
//  C_OPB_DWIDTH  32            OPB data width
//  C_FAMILY      "virtex6"     target family string
//  C_NUM_CH      4             channels, 1..32
//  C_DATA_W      32            bits per channel, 1..32
// PORTS
//  OPB_Clk        in   1            sole clock; all logic rising-edge
//  OPB_Rst        in   1            reset, synchronous, active-high
//  OPB_ABus       in   [0:31]       address
//  OPB_BE         in   [0:3]        byte enables; BE[3] covers DBus[24:31]
//  OPB_DBus       in   [0:31]       write data
//  OPB_RNW        in   1            1 = read
//  OPB_select     in   1            transfer request
//  OPB_seqAddr    in   1            ignored
//  Sl_DBus        out  [0:31]       read data; all-zero when Sl_xferAck=0 (wired-OR bus)
//  Sl_xferAck     out  1            transfer acknowledge
//  Sl_errAck      out  1            tied 0
//  Sl_retry       out  1            tied 0
//  Sl_toutSup     out  1            tied 0
//  user_data_in   in   C_NUM_CH*C_DATA_W  channel i at [i*C_DATA_W +: C_DATA_W]
//  user_valid_in  in   C_NUM_CH     per-channel valid strobe
// BEHAVIOUR
//  Map (byte offset from C_BASEADDR): 0x00 CTRL, 0x04 STATUS, 0x08 TSTAMP, 0x10+4*i CH[i]; other in-range offsets read 0, writes dropped.
//  CTRL: DBus[31]=mode (RW; 0 live, 1 snapshot), DBus[30]=snap (write-1 pulse, reads 0); written only when BE[3]=1.
//  STATUS: DBus[16:31]=snap_count (RO). CH[i]: shadow[i] zero-extended into DBus LSBs; RO, writes dropped.
//  hit = OPB_select & (C_BASEADDR <= OPB_ABus <= C_HIGHADDR).
//  Handshake: Sl_xferAck <= hit & ~Sl_xferAck; exactly one-cycle pulse, 1-cycle latency; select held -> ack every 2nd cycle.
//  Sl_DBus registered alongside ack from address/shadow sampled in request cycle; zero otherwise.
//  Write takes effect on the ack cycle (CTRL registered at same edge as ack is raised).
//  Live mode: shadow[i] <= user_data_in[i] on any cycle user_valid_in[i]=1; else hold.
//  Snapshot mode: shadow frozen; valids ignored.
//  Snap pulse (either mode): all shadows <= current user_data_in (valids ignored) in one edge; snap_count++.
//  Snap and valid same cycle: snap wins (identical data). Mode and snap written together: new mode applies after capture.
//  Read of CH in same cycle shadow updates returns pre-update value.
//  snap_count 16 bits, wraps 0xFFFF -> 0x0000.
//  Reset: Sl_xferAck=0, Sl_DBus=0, shadows=0, mode=0, snap_count=0, tstamp=0; transfer in flight is dropped
//   (no ack); master retries/times out.
// CONFIGURATION
//  OPB_REG_BANK_TSTAMP_EN defined: 32-bit free-running cycle counter (reset 0, wraps), copied to TSTAMP
//   on each snap pulse; TSTAMP reads captured value.
//  Undefined: no counter; TSTAMP offset reads 0x00000000.
// TESTING
//  Reset, read CH0..CH3 and STATUS -> each ack one cycle after select, data 0, Sl_DBus 0 outside ack.
//  Live: user ch2=0xDEADBEEF valid 1 cycle, then 0x1 without valid; read CH2 -> 0xDEADBEEF.
//  Write CTRL=0x1 then 0x3; change inputs; read CHs -> values at snap edge; STATUS=0x0001.
//  Hold select 6 cycles on CH0 -> exactly 3 ack pulses, non-consecutive.
//  Write CTRL with BE=4'b0000 -> mode unchanged; address C_HIGHADDR+4 -> no ack, Sl_DBus 0.
//  65536 snaps -> STATUS 0x0000; with TSTAMP_EN snap at cycle 100 after reset -> TSTAMP=100 (+/-pipeline const, fixed).

Source files
------------

// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB register bank: C_NUM_CH read-only user channels with per-channel valid
// qualification, live/snapshot mode, atomic snap capture and a snap counter.
// Map (word offsets): 0 CTRL, 1 STATUS, 2 TSTAMP, 4+i CH[i]; everything else reads 0.
// Optional feature macro: OPB_REG_BANK_TSTAMP_EN adds a free-running cycle
// counter whose value is latched into TSTAMP on every snap.
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h01002100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010021FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6",
    parameter int          C_NUM_CH     = 4,
    parameter int          C_DATA_W     = 32
) (
    input  logic                         OPB_Clk,
    input  logic                         OPB_Rst,
    input  logic [0:31]                  OPB_ABus,
    input  logic [0:3]                   OPB_BE,
    input  logic [0:31]                  OPB_DBus,
    input  logic                         OPB_RNW,
    input  logic                         OPB_select,
    input  logic                         OPB_seqAddr,
    output logic [0:31]                  Sl_DBus,
    output logic                         Sl_xferAck,
    output logic                         Sl_errAck,
    output logic                         Sl_retry,
    output logic                         Sl_toutSup,
    input  logic [C_NUM_CH*C_DATA_W-1:0] user_data_in,
    input  logic [C_NUM_CH-1:0]          user_valid_in
);

    // Parameter sanity; the address window must cover every channel.
    if (C_NUM_CH < 1 || C_NUM_CH > 32) begin : g_bad_num_ch
        $error("C_NUM_CH must be 1..32");
    end
    if (C_DATA_W < 1 || C_DATA_W > 32) begin : g_bad_data_w
        $error("C_DATA_W must be 1..32");
    end
    if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32) begin : g_bad_opb_w
        $error("OPB address and data widths must be 32");
    end
    if ((64'(C_HIGHADDR) - 64'(C_BASEADDR) + 64'd1) < 64'(16 + 4*C_NUM_CH)) begin : g_bad_window
        $error("C_HIGHADDR-C_BASEADDR+1 too small for C_NUM_CH channels");
    end
    if (C_FAMILY == "") begin : g_bad_family
        $error("C_FAMILY must be set");
    end

    logic [31:0] addr, offset, rd_data, tstamp_rd;
    logic [29:0] word;
    logic        hit, req, ctrl_wr, snap, mode;
    logic [15:0] snap_count;
    logic [C_NUM_CH-1:0][C_DATA_W-1:0] shadow;

    // Bits the bank never looks at.
    logic unused_bits;
    assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29], offset[1:0]};

    assign addr    = OPB_ABus;
    assign offset  = addr - C_BASEADDR;
    assign word    = offset[31:2];
    assign hit     = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    // A request is accepted only on a cycle where ack is low, so a held select
    // is acknowledged every other cycle.
    assign req     = hit && !Sl_xferAck;
    assign ctrl_wr = req && !OPB_RNW && (word == 30'd0) && OPB_BE[3];
    assign snap    = ctrl_wr && OPB_DBus[30];

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Read mux over the current (pre-update) register state.
    always_comb begin
        rd_data = '0;
        case (word)
            30'd0:   rd_data = {31'd0, mode};
            30'd1:   rd_data = {16'd0, snap_count};
            30'd2:   rd_data = tstamp_rd;
            default: rd_data = '0;
        endcase
        for (int i = 0; i < C_NUM_CH; i++) begin
            if (word == 30'(4 + i)) rd_data = 32'(shadow[i]);
        end
    end

    // Handshake and read data; the bus stays zero outside the ack cycle.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
        end else begin
            Sl_xferAck <= req;
            Sl_DBus    <= (req && OPB_RNW) ? rd_data : 32'd0;
        end
    end

    // CTRL mode bit and snap counter; a snap written with a new mode captures
    // first and the new mode governs from the following cycle.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            mode       <= 1'b0;
            snap_count <= '0;
        end else begin
            if (ctrl_wr) mode <= OPB_DBus[31];
            if (snap)    snap_count <= snap_count + 16'd1;
        end
    end

    // Shadow registers: snap captures all channels at once, otherwise live
    // mode follows each channel's valid and snapshot mode holds.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            shadow <= '0;
        end else if (snap) begin
            shadow <= user_data_in;
        end else if (!mode) begin
            for (int i = 0; i < C_NUM_CH; i++) begin
                if (user_valid_in[i]) shadow[i] <= user_data_in[i*C_DATA_W +: C_DATA_W];
            end
        end
    end

`ifdef OPB_REG_BANK_TSTAMP_EN
    logic [31:0] cycle_cnt, tstamp;

    // Free-running cycle counter, latched into TSTAMP on each snap.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            cycle_cnt <= '0;
            tstamp    <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (snap) tstamp <= cycle_cnt;
        end
    end
    assign tstamp_rd = tstamp;
`else
    assign tstamp_rd = '0;
`endif

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Self-checking bench for opb_register_bank_simulink2ppc: directed steps plus
// randomized traffic, checked every cycle against a register-level model.
module tb_opb_register_bank_simulink2ppc;
    localparam logic [31:0] BASE = 32'h01002100;
    localparam logic [31:0] HIGH = 32'h010021FF;
    localparam int NCH = 4;
    localparam int DW  = 32;
`ifdef OPB_REG_BANK_TSTAMP_EN
    localparam logic [31:0] TS_EXP = 32'd100;
`else
    localparam logic [31:0] TS_EXP = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [0:31] abus = '0;
    logic [0:31] dbus_w = '0;
    logic [0:3]  be = '0;
    logic rnw = 1'b1, sel = 1'b0, seq = 1'b0;
    logic [0:31] sl_dbus;
    logic ack, err, retry, tout;
    logic [NCH*DW-1:0] udata = '0;
    logic [NCH-1:0]    uvalid = '0;

    int n_assert = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_sh [NCH];
    logic        m_mode, m_ack;
    logic [15:0] m_cnt;
    logic [31:0] m_ts, m_cyc, m_rd;

    always #5 clk = ~clk;

    opb_register_bank_simulink2ppc #(
        .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
        .C_FAMILY("virtex6"), .C_NUM_CH(NCH), .C_DATA_W(DW)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_w),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err), .Sl_retry(retry),
        .Sl_toutSup(tout), .user_data_in(udata), .user_valid_in(uvalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] readval(input logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) >> 2;
        if (w == 0) return {31'd0, m_mode};
        if (w == 1) return {16'd0, m_cnt};
        if (w == 2) begin
`ifdef OPB_REG_BANK_TSTAMP_EN
            return m_ts;
`else
            return 32'd0;
`endif
        end
        if (w >= 4 && w < 4 + NCH) return m_sh[w - 4];
        return 32'd0;
    endfunction

    // Apply one clock of bus/user rules to the model, advance the clock and
    // compare the bus outputs.
    task automatic tick();
        logic [31:0] a, d;
        logic hit, acc, ctrl_wr, snap;
        a = abus;
        d = dbus_w;
        if (rst) begin
            for (int i = 0; i < NCH; i++) m_sh[i] = 32'd0;
            m_mode = 1'b0; m_ack = 1'b0; m_cnt = 16'd0; m_ts = 32'd0; m_cyc = 32'd0; m_rd = 32'd0;
        end else begin
            hit     = sel && (a >= BASE) && (a <= HIGH);
            acc     = hit && !m_ack;
            m_rd    = (acc && rnw) ? readval(a) : 32'd0;
            ctrl_wr = acc && !rnw && ((a - BASE) >> 2) == 0 && be[3];
            snap    = ctrl_wr && d[1];
            if (snap) begin
                for (int i = 0; i < NCH; i++) m_sh[i] = 32'(udata[i*DW +: DW]);
                m_cnt = m_cnt + 16'd1;
                m_ts  = m_cyc;
            end else if (!m_mode) begin
                for (int i = 0; i < NCH; i++)
                    if (uvalid[i]) m_sh[i] = 32'(udata[i*DW +: DW]);
            end
            if (ctrl_wr) m_mode = d[0];
            m_ack = acc;
            m_cyc = m_cyc + 32'd1;
        end
        @(posedge clk);
        #1;
        chk("ack", {31'd0, ack}, {31'd0, m_ack});
        chk("sl_dbus", sl_dbus, m_rd);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        sel = 1'b1; rnw = 1'b1; abus = a;
        tick();
        d = sl_dbus;
        sel = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] data, input logic [3:0] b);
        sel = 1'b1; rnw = 1'b0; abus = a; dbus_w = data; be = b;
        tick();
        sel = 1'b0; rnw = 1'b1; dbus_w = '0; be = '0;
        tick();
    endtask

    initial begin
        logic [31:0] d, a;
        int nack, consec;
        logic prev;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("tied_outputs", {29'd0, err, retry, tout}, 32'd0);
        for (int ch = 0; ch < NCH; ch++) begin
            rd(BASE + 32'h10 + 4*ch, d);
            chk($sformatf("reset_ch%0d", ch), d, 32'd0);
        end
        rd(BASE + 32'h4, d);
        chk("reset_status", d, 32'd0);

        // Live mode: valid captures, later data without valid is ignored
        udata[2*DW +: DW] = 32'hDEADBEEF; uvalid = 4'b0100;
        tick();
        uvalid = '0; udata[2*DW +: DW] = 32'h1;
        tick();
        rd(BASE + 32'h18, d);
        chk("live_ch2", d, 32'hDEADBEEF);

        // Snapshot mode then snap
        wr(BASE, 32'h1, 4'hF);
        rd(BASE, d);
        chk("ctrl_mode1", d, 32'h1);
        for (int ch = 0; ch < NCH; ch++) udata[ch*DW +: DW] = 32'h5A5A_0000 + ch;
        uvalid = '1;
        repeat (3) tick();
        uvalid = '0;
        rd(BASE + 32'h10, d);
        chk("frozen_ch0", d, 32'h0);
        for (int ch = 0; ch < NCH; ch++) udata[ch*DW +: DW] = 32'h1111_0000 + ch;
        wr(BASE, 32'h3, 4'hF);
        udata = {$urandom, $urandom, $urandom, $urandom};
        uvalid = '1;
        repeat (4) tick();
        uvalid = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            rd(BASE + 32'h10 + 4*ch, d);
            chk($sformatf("snap_ch%0d", ch), d, 32'h1111_0000 + ch);
        end
        rd(BASE + 32'h4, d);
        chk("status_one", d, 32'h1);

        // CTRL write with no byte enables leaves mode alone
        wr(BASE, 32'h0, 4'h0);
        rd(BASE, d);
        chk("be0_mode", d, 32'h1);

        // Select held for 6 cycles
        sel = 1'b1; rnw = 1'b1; abus = BASE + 32'h10;
        nack = 0; consec = 0; prev = ack;
        repeat (6) begin
            tick();
            if (ack) nack++;
            if (ack && prev) consec++;
            prev = ack;
        end
        sel = 1'b0;
        tick();
        chk("hold_acks", nack, 3);
        chk("hold_consecutive", consec, 0);

        // Out of range address
        sel = 1'b1; abus = HIGH + 32'd4;
        tick();
        chk("oor_ack", {31'd0, ack}, 32'd0);
        chk("oor_dbus", sl_dbus, 32'd0);
        sel = 1'b0;
        tick();

        // Reset during a request drops it
        sel = 1'b1; rnw = 1'b1; abus = BASE + 32'h10; rst = 1'b1;
        tick();
        chk("reset_drop_ack", {31'd0, ack}, 32'd0);
        sel = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic
        repeat (600) begin
            udata  = {$urandom, $urandom, $urandom, $urandom};
            uvalid = 4'($urandom);
            sel    = ($urandom_range(0, 2) != 0);
            rnw    = ($urandom_range(0, 2) != 0);
            be     = 4'($urandom);
            dbus_w = $urandom;
            case ($urandom_range(0, 9))
                0:       a = HIGH + 32'd1 + 4*$urandom_range(0, 3);
                1:       a = BASE - 4*$urandom_range(1, 3);
                2:       a = HIGH - 32'd3;
                default: a = BASE + 4*$urandom_range(0, 11);
            endcase
            abus = a;
            tick();
        end
        sel = 1'b0; rnw = 1'b1; uvalid = '0; be = '0; dbus_w = '0;
        repeat (2) tick();

        // 1000 back-to-back snaps from a held CTRL write
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        sel = 1'b1; rnw = 1'b0; abus = BASE; be = 4'hF; dbus_w = 32'h2;
        repeat (2000) tick();
        sel = 1'b0; rnw = 1'b1; be = '0; dbus_w = '0;
        tick();
        rd(BASE + 32'h4, d);
        chk("status_1000", d, 32'd1000);

        // Timestamp of a snap issued on cycle 100 after reset
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (100) tick();
        wr(BASE, 32'h2, 4'hF);
        rd(BASE + 32'h8, d);
        chk("tstamp", d, TS_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
